// File: rtl/mdu_pkg.sv
// Shared encodings, widths and result payload for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [DATA_W-1:0] DIV0_FILL = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  function automatic logic is_compute_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> multiply/divide unit signal bundle; master is the pipeline side.
interface mdu_if;
  import mdu_pkg::*;

  logic [OP_W-1:0]   md_op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              md_instr_D;
  logic              flush;
  logic              busy;
  logic              start;
  logic              stall_md;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output md_op, rs_data, rt_data, md_instr_D, flush,
    input  busy, start, stall_md, hi, lo
  );

  modport slave (
    input  md_op, rs_data, rt_data, md_instr_D, flush,
    output busy, start, stall_md, hi, lo
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational product / quotient-remainder generator, including the
// divide-by-zero fill and the INT_MIN / -1 overflow result.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e            i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  output md_result_t        o_res_c
);

  logic signed [2*DATA_W-1:0] w_prod_s;
  logic        [2*DATA_W-1:0] w_prod_u;
  logic                       w_rt_zero;
  logic                       w_ovf;
  logic        [DATA_W-1:0]   w_div_u;
  logic        [DATA_W-1:0]   w_quo_u;
  logic        [DATA_W-1:0]   w_rem_u;
  logic signed [DATA_W-1:0]   w_div_s;
  logic signed [DATA_W-1:0]   w_quo_s;
  logic signed [DATA_W-1:0]   w_rem_s;

  assign w_prod_s = $signed({{DATA_W{i_rs[DATA_W-1]}}, i_rs}) *
                    $signed({{DATA_W{i_rt[DATA_W-1]}}, i_rt});
  assign w_prod_u = {{DATA_W{1'b0}}, i_rs} * {{DATA_W{1'b0}}, i_rt};

  assign w_rt_zero = (i_rt == '0);
  assign w_ovf     = (i_rs == INT_MIN) && (i_rt == '1);

  // Divisors are steered to 1 in the special cases so the dividers never see 0 or overflow
  assign w_div_u = w_rt_zero ? DATA_W'(1) : i_rt;
  assign w_div_s = (w_rt_zero || w_ovf) ? $signed(DATA_W'(1)) : $signed(i_rt);

  assign w_quo_u = i_rs / w_div_u;
  assign w_rem_u = i_rs % w_div_u;
  assign w_quo_s = $signed(i_rs) / w_div_s;
  assign w_rem_s = $signed(i_rs) % w_div_s;

  always_comb begin
    o_res_c = '0;
    case (i_op)
      MD_MULT:  o_res_c = md_result_t'(w_prod_s);
      MD_MULTU: o_res_c = md_result_t'(w_prod_u);
      MD_DIV: begin
        if (w_rt_zero)  o_res_c = {i_rs, DIV0_FILL};
        else if (w_ovf) o_res_c = {DATA_W'(0), INT_MIN};
        else            o_res_c = {w_rem_s, w_quo_s};
      end
      MD_DIVU: begin
        if (w_rt_zero)  o_res_c = {i_rs, DIV0_FILL};
        else            o_res_c = {w_rem_u, w_quo_u};
      end
      default: o_res_c = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO, with a fixed-latency
// busy counter and D-stage stall request. MDU_FLUSH_EN enables in-flight cancel.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
)
(
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  md_result_t        r_shadow;

  md_op_e            w_op;
  md_result_t        w_result;
  logic              w_start;
  logic              w_flush;

  assign w_op = md_op_e'(bus.md_op);

`ifdef MDU_FLUSH_EN
  assign w_flush = bus.flush;
`else
  logic w_flush_unused;
  assign w_flush_unused = bus.flush;
  assign w_flush        = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) && is_compute_op(w_op) && !w_flush;

  mdu_arith u_arith (
    .i_op    (w_op),
    .i_rs    (bus.rs_data),
    .i_rt    (bus.rt_data),
    .o_res_c (w_result)
  );

  // FSM, latency counter, shadow result and architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_shadow <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_shadow <= w_result;
            r_cnt    <= ((w_op == MD_MULT) || (w_op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
            r_busy   <= 1'b1;
            r_state  <= ST_BUSY;
          end else if (!w_flush && (w_op == MD_MTHI)) begin
            r_hi <= bus.rs_data;
          end else if (!w_flush && (w_op == MD_MTLO)) begin
            r_lo <= bus.rs_data;
          end
        end
        ST_BUSY: begin
          if (w_flush) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_shadow.hi;
            r_lo    <= r_shadow.lo;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.start    = w_start;
  assign bus.stall_md = bus.md_instr_D & (w_start | r_busy);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller in the E stage, next to the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
- Models the fixed latency of the hardware multiplier/divider with a busy counter.
- Raises a stall request so that any MD-class instruction in D waits until the unit is free.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu, legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_data  in  32  forwarded rs operand from E.
- rt_data  in  32  forwarded rt operand from E.
- md_instr_D  in  1  the D-stage instruction is MD-class (mult/div/mfhi/mflo/mthi/mtlo).
- flush  in  1  cancels the in-flight operation; used only under MDU_FLUSH_EN.
- busy  out  1  the unit is computing.
- start  out  1  combinational: 1 when md_op is 1..4 and the unit is idle.
- stall_md  out  1  combinational: md_instr_D & (start | busy).
- hi  out  32  HI register, read by mfhi.
- lo  out  32  LO register, read by mflo.

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE; cnt = 0; busy = 0; hi = 0; lo = 0; shadow regs = 0.
- States: IDLE and BUSY.
- IDLE with md_op in 1..4 at the clock edge:
  - Compute the result and capture it in shadow_hi/shadow_lo.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to BUSY; busy = 1 from the next cycle.
- Result arithmetic (all 32-bit):
  - mult: signed 32x32 -> 64; shadow_hi = [63:32], shadow_lo = [31:0].
  - multu: same, unsigned.
  - div: shadow_lo = signed quotient, shadow_hi = signed remainder. Truncate toward zero; the remainder takes the sign of the dividend.
  - divu: same, unsigned.
  - div/divu with rt_data == 0: shadow_lo = 32'hFFFF_FFFF, shadow_hi = rs_data. Latency is unchanged.
  - div with rs = 32'h8000_0000 and rt = 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
- BUSY:
  - cnt decrements every cycle.
  - In the cycle cnt == 1, the next edge writes hi/lo from the shadow regs, clears busy and returns to IDLE.
  - hi/lo keep their old values while BUSY.
- Total latency: results are visible in hi/lo exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES); busy is high for N cycles.
- mthi/mtlo, IDLE only: at the edge, hi = rs_data (mthi) or lo = rs_data (mtlo). Single cycle, busy never set.
- md_op != 0 while BUSY:
  - Ignored. This cannot happen legally because stall_md holds MD instructions in D.
  - The bench flags it as an error.
- Single completion path: the BUSY completion and a new start cannot coincide, because start requires IDLE. A new op may start in the cycle after busy falls.
- Reset mid-operation: the operation is abandoned, hi/lo = 0, state = IDLE.
- stall_md is asserted in the start cycle, so the D instruction does not enter E in the cycle the unit is being loaded.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- Defined: flush == 1 in BUSY forces IDLE at the next edge, with cnt = 0 and busy = 0. hi/lo keep their pre-operation values and the shadow result is discarded.
  - flush in IDLE also suppresses start, mthi and mtlo in that cycle.
  - flush has priority over completion when cnt == 1.
- Undefined: the flush port exists but is ignored; operations always complete.

Decomposition:
- Shared package (e.g. mdu_pkg):
  - MD_NONE..MD_MTLO op encodings.
  - State encoding.
  - DIV0 fill constant 32'hFFFF_FFFF.
- One natural sub-module: mdu_arith, a purely combinational 64-bit product / quotient-remainder generator including the div-by-zero and overflow rules.
- mdu_ctrl keeps the FSM, counter, shadow and HI/LO registers.

Test Plan:
- mult, rs = 32'hFFFF_FFFE (-2), rt = 3:
  - busy high for 5 cycles.
  - After 5 edges, hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFFA; hi/lo unchanged before that.
- divu, rs = 100, rt = 7, with md_instr_D = 1 throughout:
  - stall_md = 1 for the start cycle plus 10 busy cycles, then 0.
  - hi = 2, lo = 14.
- div, rs = -7, rt = 2, gives hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFFD. div by zero with rs = 5 gives hi = 5, lo = 32'hFFFF_FFFF after 10 cycles.
- mthi rs = 32'h1234_5678 then mtlo rs = 32'h9ABC_DEF0 in consecutive cycles: hi and lo update on the respective edges and busy stays 0.
- Assert reset low 3 cycles into a mult: busy, hi and lo drop to 0 immediately (asynchronously); the next mult completes normally.
- Under MDU_FLUSH_EN, flush on cycle 4 of a div: busy = 0 next edge, hi/lo keep their prior values, and a mult issued next cycle completes in 5 cycles.
